// File: rtl/debug_tx_scheduler_pkg.sv
// rtl/debug_tx_scheduler_pkg.sv - states and frame word constants for the debug TX scheduler
package debug_tx_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TRIG_HDR  = 3'd1,
        TRIG_CMD  = 3'd2,
        PORT_HDR  = 3'd3,
        PORT_DATA = 3'd4,
        GAP       = 3'd5
    } state_t;

    localparam logic [31:0] HDR_TRIG  = 32'h0000_0000;
    localparam logic [31:0] CMD_TRIG  = 32'hFFFF_FFFF;
    localparam logic [7:0]  HDR_PORT  = 8'hFF;
    localparam logic [7:0]  HDR_ABORT = 8'hEE;
    localparam logic [7:0]  K28_5     = 8'hBC;
    localparam logic [3:0]  K_COMMA   = 4'b0001;
    localparam logic [3:0]  K_DATA    = 4'b0000;

    function automatic logic [31:0] ctl_word(input logic [7:0] tag, input logic [7:0] port);
        return {tag, 16'h0000, port};
    endfunction

endpackage

// File: rtl/debug_tx_scheduler_rr_arbiter.sv
// rtl/debug_tx_scheduler_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] index,
    output logic          any
);

    always_comb begin
        int j;
        j     = 0;
        gnt   = '0;
        index = '0;
        any   = 1'b0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr) + k;
            if (j >= N) j = j - N;
            if (!any && req[j]) begin
                any    = 1'b1;
                gnt[j] = 1'b1;
                index  = IW'(j);
            end
        end
    end

endmodule

// File: rtl/debug_tx_scheduler.sv
// rtl/debug_tx_scheduler.sv - sequences trigger and per-port readout frames onto the shared TX lane
module debug_tx_scheduler
    import debug_tx_scheduler_pkg::*;
#(
    parameter int          PORT_NUM  = 3,
    parameter int          TIMEOUT   = 1023,
    parameter logic [31:0] IDLE_WORD = {24'h0, K28_5}
) (
    input  logic                   txclk,
    input  logic                   rstn,
    input  logic [PORT_NUM-1:0]    trigdone,
    input  logic [PORT_NUM-1:0]    port_req,
    input  logic [PORT_NUM-1:0]    port_valid,
    input  logic [PORT_NUM-1:0]    port_last,
    input  logic [PORT_NUM*32-1:0] port_data,
    output logic [PORT_NUM-1:0]    port_grant,
    output logic [31:0]            tx_data,
    output logic [3:0]             tx_k,
    output logic                   tx_valid,
    output logic                   tx_last,
    output logic                   busy
);

    localparam int IW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    state_t              state, next_state;
    logic [PORT_NUM-1:0] trig_pend;
    logic [IW-1:0]       rr_ptr, sel;
    logic [WW-1:0]       wdog;

    logic [PORT_NUM-1:0] arb_gnt;
    logic [IW-1:0]       arb_idx;
    logic                arb_any;

    logic                sel_valid, sel_last, done, abort;
    logic [31:0]         sel_data;

    logic [31:0]         d_data;
    logic [3:0]          d_k;
    logic                d_valid, d_last;
    logic [PORT_NUM-1:0] d_grant;

    rr_arbiter #(.N(PORT_NUM), .IW(IW)) u_arb (
        .req   (port_req),
        .ptr   (rr_ptr),
        .gnt   (arb_gnt),
        .index (arb_idx),
        .any   (arb_any)
    );

    assign sel_valid = port_valid[sel];
    assign sel_last  = port_last[sel];
    assign sel_data  = port_data[{sel, 5'b00000} +: 32];
    assign done      = (state == PORT_DATA) && sel_valid && sel_last;
    assign abort     = (state == PORT_DATA) && !sel_valid && (wdog == WW'(TIMEOUT));
    assign busy      = (state != IDLE);

    always_ff @(posedge txclk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (&trig_pend)   next_state = TRIG_HDR;
                else if (arb_any) next_state = PORT_HDR;
            end
            TRIG_HDR:  next_state = TRIG_CMD;
            TRIG_CMD:  next_state = IDLE;
            PORT_HDR:  next_state = PORT_DATA;
            PORT_DATA: if (done || abort) next_state = GAP;
            GAP:       next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Values computed here land on the lane one cycle later, so headers
    // appear the cycle after the IDLE decision.
    always_comb begin
        d_data  = IDLE_WORD;
        d_k     = K_COMMA;
        d_valid = 1'b0;
        d_last  = 1'b0;
        d_grant = '0;
        case (state)
            IDLE: begin
                if (next_state == TRIG_HDR) begin
                    d_data  = HDR_TRIG;
                    d_k     = K_DATA;
                    d_valid = 1'b1;
                end else if (next_state == PORT_HDR) begin
                    d_data  = ctl_word(HDR_PORT, 8'(arb_idx));
                    d_k     = K_DATA;
                    d_valid = 1'b1;
                    d_grant = arb_gnt;
                end
            end
            TRIG_HDR: begin
                d_data  = CMD_TRIG;
                d_k     = K_DATA;
                d_valid = 1'b1;
                d_last  = 1'b1;
            end
            PORT_HDR: d_grant = port_grant;
            PORT_DATA: begin
                d_grant = (done || abort) ? '0 : port_grant;
                if (abort) begin
                    d_data  = ctl_word(HDR_ABORT, 8'(sel));
                    d_k     = K_DATA;
                    d_valid = 1'b1;
                    d_last  = 1'b1;
                end else if (sel_valid) begin
                    d_data  = sel_data;
                    d_k     = K_DATA;
                    d_valid = 1'b1;
                    d_last  = sel_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge txclk or negedge rstn) begin
        if (!rstn) begin
            tx_data    <= IDLE_WORD;
            tx_k       <= K_COMMA;
            tx_valid   <= 1'b0;
            tx_last    <= 1'b0;
            port_grant <= '0;
        end else begin
            tx_data    <= d_data;
            tx_k       <= d_k;
            tx_valid   <= d_valid;
            tx_last    <= d_last;
            port_grant <= d_grant;
        end
    end

    // A trigdone landing on the clearing cycle survives, so no capture is lost.
    always_ff @(posedge txclk or negedge rstn) begin
        if (!rstn) begin
            trig_pend <= '0;
            rr_ptr    <= '0;
            sel       <= '0;
            wdog      <= '0;
        end else begin
            trig_pend <= ((state == TRIG_HDR) ? '0 : trig_pend) | trigdone;
            if (state == IDLE && next_state == PORT_HDR)
                sel <= arb_idx;
            if (done || abort)
                rr_ptr <= (sel == IW'(PORT_NUM - 1)) ? '0 : sel + 1'b1;
            if (state != PORT_DATA || sel_valid || abort)
                wdog <= '0;
            else
                wdog <= wdog + 1'b1;
        end
    end

endmodule

// File: tb/tb_debug_tx_scheduler.sv
// tb/tb_debug_tx_scheduler.sv - directed vector bench for debug_tx_scheduler
module tb_debug_tx_scheduler;

    localparam logic [31:0] IDLE_W = 32'h0000_00BC;
    localparam int          TMO    = 1023;

    logic        txclk = 1'b0;
    logic        rstn  = 1'b0;
    logic [2:0]  trigdone = '0, port_req = '0, port_valid = '0, port_last = '0;
    logic [95:0] port_data = '0;
    logic [2:0]  port_grant;
    logic [31:0] tx_data;
    logic [3:0]  tx_k;
    logic        tx_valid, tx_last, busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  td, req, pv, pl;
        logic [95:0] pd;
        logic [31:0] e_data;
        logic [3:0]  e_k;
        logic        e_v, e_l;
        logic [2:0]  e_g;
        logic        e_busy;
    } vec_t;

    vec_t vecs[$];

    debug_tx_scheduler #(.PORT_NUM(3), .TIMEOUT(TMO), .IDLE_WORD(IDLE_W)) dut (
        .txclk      (txclk),
        .rstn       (rstn),
        .trigdone   (trigdone),
        .port_req   (port_req),
        .port_valid (port_valid),
        .port_last  (port_last),
        .port_data  (port_data),
        .port_grant (port_grant),
        .tx_data    (tx_data),
        .tx_k       (tx_k),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .busy       (busy)
    );

    always #5 txclk = ~txclk;

    function automatic vec_t mk(input logic [2:0] td, input logic [2:0] req, input logic [2:0] pv,
                                input logic [2:0] pl, input logic [95:0] pd, input logic [31:0] d,
                                input logic [3:0] k, input logic v, input logic l,
                                input logic [2:0] g, input logic b);
        vec_t r;
        r.td = td; r.req = req; r.pv = pv; r.pl = pl; r.pd = pd;
        r.e_data = d; r.e_k = k; r.e_v = v; r.e_l = l; r.e_g = g; r.e_busy = b;
        return r;
    endfunction

    function automatic vec_t mkidle(input logic [2:0] td, input logic [2:0] req,
                                    input logic [2:0] g, input logic b);
        return mk(td, req, 3'b000, 3'b000, 96'h0, IDLE_W, 4'b0001, 1'b0, 1'b0, g, b);
    endfunction

    function automatic logic [95:0] pd_of(input int p, input logic [31:0] d);
        logic [95:0] r;
        r = 96'h0;
        r[32*p +: 32] = d;
        return r;
    endfunction

    function automatic logic [31:0] word(input int p, input int w);
        return 32'hA000_0000 | (32'(p) << 8) | 32'(w);
    endfunction

    task automatic check_out(input vec_t v, input string nm);
        checks++;
        if (tx_data !== v.e_data || tx_k !== v.e_k || tx_valid !== v.e_v ||
            tx_last !== v.e_l || port_grant !== v.e_g || busy !== v.e_busy) begin
            errors++;
            $display("FAIL %s: got data=%h k=%b v=%b l=%b g=%b busy=%b want data=%h k=%b v=%b l=%b g=%b busy=%b",
                     nm, tx_data, tx_k, tx_valid, tx_last, port_grant, busy,
                     v.e_data, v.e_k, v.e_v, v.e_l, v.e_g, v.e_busy);
        end
    endtask

    task automatic apply_check(input vec_t v, input string nm);
        trigdone   = v.td;
        port_req   = v.req;
        port_valid = v.pv;
        port_last  = v.pl;
        port_data  = v.pd;
        @(posedge txclk);
        #1;
        check_out(v, nm);
    endtask

    initial begin
        int cnt;
        bit found;
        logic [2:0] pv, pl, reqd;
        logic [95:0] pd;

        // trigger frame once all three ports have pulsed
        vecs.push_back(mkidle(3'b000, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mkidle(3'b001, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mkidle(3'b100, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mkidle(3'b010, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 96'h0, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b1));
        vecs.push_back(mk(3'b000, 3'b000, 3'b000, 3'b000, 96'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1));
        vecs.push_back(mkidle(3'b000, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mkidle(3'b000, 3'b000, 3'b000, 1'b0));
        vecs.push_back(mkidle(3'b000, 3'b000, 3'b000, 1'b0));

        // three round-robin readout frames of four words each
        for (int p = 0; p < 3; p++) begin
            reqd = (p == 2) ? 3'b000 : 3'b111;
            vecs.push_back(mk(3'b000, 3'b111, 3'b000, 3'b000, 96'h0, {8'hFF, 16'h0, 8'(p)},
                              4'b0000, 1'b1, 1'b0, 3'(1 << p), 1'b1));
            vecs.push_back(mkidle(3'b000, reqd, 3'(1 << p), 1'b1));
            for (int w = 0; w < 4; w++) begin
                pv = 3'(1 << p);
                pl = (w == 3) ? 3'(1 << p) : 3'b000;
                pd = pd_of(p, word(p, w));
                if (p == 0 && w == 1) begin
                    pv = pv | 3'b010;
                    pl = pl | 3'b010;
                    pd = pd | pd_of(1, 32'hDEAD_BEEF);
                end
                vecs.push_back(mk(3'b000, reqd, pv, pl, pd, word(p, w), 4'b0000, 1'b1,
                                  (w == 3), (w == 3) ? 3'b000 : 3'(1 << p), 1'b1));
            end
            vecs.push_back(mkidle(3'b000, reqd, 3'b000, 1'b0));
        end
        vecs.push_back(mkidle(3'b000, 3'b000, 3'b000, 1'b0));

        repeat (2) @(posedge txclk);
        #1;
        check_out(mkidle(3'b000, 3'b000, 3'b000, 1'b0), "reset_state");
        rstn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            apply_check(vecs[i], $sformatf("vec%0d", i));

        // watchdog abort on port 1, then port 2 is next in line
        apply_check(mk(3'b000, 3'b010, 3'b000, 3'b000, 96'h0, 32'hFF00_0001, 4'b0000, 1'b1, 1'b0, 3'b010, 1'b1), "to_hdr");
        apply_check(mkidle(3'b000, 3'b110, 3'b010, 1'b1), "to_enter");
        cnt = 0;
        found = 1'b0;
        while (!found && cnt < 2000) begin
            trigdone = '0; port_req = 3'b110; port_valid = '0; port_last = '0; port_data = '0;
            @(posedge txclk);
            #1;
            cnt++;
            if (tx_valid === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found || cnt != TMO + 1) begin
            errors++;
            $display("FAIL to_latency: got found=%0d cycles=%0d want cycles=%0d", found, cnt, TMO + 1);
        end
        check_out(mk(3'b000, 3'b110, 3'b000, 3'b000, 96'h0, 32'hEE00_0001, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1), "to_abort");
        apply_check(mkidle(3'b000, 3'b110, 3'b000, 1'b0), "to_gap");
        apply_check(mk(3'b000, 3'b110, 3'b000, 3'b000, 96'h0, 32'hFF00_0002, 4'b0000, 1'b1, 1'b0, 3'b100, 1'b1), "to_next");

        // reset while port 2 is mid-frame
        apply_check(mkidle(3'b000, 3'b100, 3'b100, 1'b1), "rst_enter");
        apply_check(mk(3'b000, 3'b100, 3'b100, 3'b000, pd_of(2, word(2, 5)), word(2, 5), 4'b0000, 1'b1, 1'b0, 3'b100, 1'b1), "rst_w1");
        port_data = pd_of(2, word(2, 6));
        #2 rstn = 1'b0;
        @(posedge txclk);
        #1;
        check_out(mkidle(3'b000, 3'b100, 3'b000, 1'b0), "rst_mid");
        rstn = 1'b1;
        apply_check(mkidle(3'b000, 3'b000, 3'b000, 1'b0), "rst_after");

        // trigger arriving mid-readout waits for GAP; pulse on clear cycle survives
        apply_check(mk(3'b000, 3'b001, 3'b000, 3'b000, 96'h0, 32'hFF00_0000, 4'b0000, 1'b1, 1'b0, 3'b001, 1'b1), "col_hdr");
        apply_check(mkidle(3'b000, 3'b001, 3'b001, 1'b1), "col_enter");
        apply_check(mk(3'b111, 3'b001, 3'b001, 3'b000, pd_of(0, word(0, 8)), word(0, 8), 4'b0000, 1'b1, 1'b0, 3'b001, 1'b1), "col_w0");
        apply_check(mk(3'b000, 3'b001, 3'b001, 3'b001, pd_of(0, word(0, 9)), word(0, 9), 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1), "col_w1");
        apply_check(mkidle(3'b000, 3'b001, 3'b000, 1'b0), "col_gap");
        apply_check(mk(3'b000, 3'b000, 3'b000, 3'b000, 96'h0, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b1), "col_trig_hdr");
        apply_check(mk(3'b111, 3'b000, 3'b000, 3'b000, 96'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1), "col_trig_cmd");
        apply_check(mkidle(3'b000, 3'b000, 3'b000, 1'b0), "col_idle");
        apply_check(mk(3'b000, 3'b000, 3'b000, 3'b000, 96'h0, 32'h0000_0000, 4'b0000, 1'b1, 1'b0, 3'b000, 1'b1), "keep_hdr");
        apply_check(mk(3'b000, 3'b000, 3'b000, 3'b000, 96'h0, 32'hFFFF_FFFF, 4'b0000, 1'b1, 1'b1, 3'b000, 1'b1), "keep_cmd");
        apply_check(mkidle(3'b000, 3'b000, 3'b000, 1'b0), "keep_idle0");
        apply_check(mkidle(3'b000, 3'b000, 3'b000, 1'b0), "keep_idle1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
